// File: rtl/game_pkg.sv
// Shared definitions for the gravity-flip game engine: FSM states and lane geometry.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } game_state_t;

   // Lane k (k=0 lowest) sits one pitch above the previous one.
   function automatic int lane_y(input int k, input int spacing);
      return (k + 1) * spacing;
   endfunction

   function automatic int start_h(input int num_lanes, input int spacing);
      return lane_y(num_lanes / 2, spacing);
   endfunction

endpackage

// File: rtl/player_slot.sv
// One player's datapath: height, gravity direction, pending flip, alive flag and survival score.
module player_slot
   import game_pkg::*;
#(
   parameter int HEIGHT_W     = 9,
   parameter int NUM_LANES    = 3,
   parameter int LANE_SPACING = 120,
   parameter int FALL_STEP    = 4,
   parameter int MAX_H        = 479,
   parameter int SCORE_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick_en,
   input  logic                 toggle_en,
   input  logic                 load,
   input  logic                 load_alive,
   input  logic [NUM_LANES-1:0] lines,
   output logic [HEIGHT_W-1:0]  height,
   output logic                 grav_dir,
   output logic                 alive,
   output logic [SCORE_W-1:0]   score,
   output logic                 alive_next
);

   localparam int EXT_W = HEIGHT_W + 1;
   localparam logic [HEIGHT_W-1:0] START_H  = HEIGHT_W'(start_h(NUM_LANES, LANE_SPACING));
   localparam logic [EXT_W-1:0]    STEP_EXT = EXT_W'(FALL_STEP);
   localparam logic [EXT_W-1:0]    MAX_EXT  = EXT_W'(MAX_H);

   function automatic logic [EXT_W-1:0] lane_ext(input int k);
      return EXT_W'(lane_y(k, LANE_SPACING));
   endfunction

   logic [HEIGHT_W-1:0] height_reg, height_next;
   logic                dir_reg, dir_next;
   logic                alive_reg;
   logic                pending_reg;
   logic [SCORE_W-1:0]  score_reg;

   logic [EXT_W-1:0] h_ext, up_sum, down_land, up_land;
   logic             grounded, flip, dir_eff, move, down_found, up_found;

   always_comb begin
      h_ext      = {1'b0, height_reg};
      up_sum     = h_ext + STEP_EXT;
      grounded   = 1'b0;
      down_found = 1'b0;
      down_land  = '0;
      up_found   = 1'b0;
      up_land    = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (lines[k] && lane_ext(k) == h_ext)
            grounded = 1'b1;
         // Ascending scan: the last hit is the highest lane below us.
         if (lines[k] && lane_ext(k) < h_ext && lane_ext(k) + STEP_EXT >= h_ext) begin
            down_found = 1'b1;
            down_land  = lane_ext(k);
         end
      end
      // Descending scan: the last hit is the lowest lane above us.
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         if (lines[k] && lane_ext(k) > h_ext && lane_ext(k) <= up_sum) begin
            up_found = 1'b1;
            up_land  = lane_ext(k);
         end
      end

      flip    = grounded && (pending_reg || toggle_en);
      dir_eff = flip ? ~dir_reg : dir_reg;
      move    = !grounded || flip;

      height_next = height_reg;
      dir_next    = dir_reg;
      alive_next  = alive_reg;
      if (alive_reg && tick_en) begin
         dir_next = dir_eff;
         if (move) begin
            if (!dir_eff) begin
               if (down_found)
                  height_next = down_land[HEIGHT_W-1:0];
               else if (h_ext <= STEP_EXT) begin
                  height_next = '0;
                  alive_next  = 1'b0;
               end else
                  height_next = height_reg - STEP_EXT[HEIGHT_W-1:0];
            end else begin
               if (up_found)
                  height_next = up_land[HEIGHT_W-1:0];
               else if (up_sum >= MAX_EXT) begin
                  height_next = MAX_EXT[HEIGHT_W-1:0];
                  alive_next  = 1'b0;
               end else
                  height_next = up_sum[HEIGHT_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         height_reg  <= START_H;
         dir_reg     <= 1'b0;
         alive_reg   <= 1'b0;
         pending_reg <= 1'b0;
         score_reg   <= '0;
      end else if (load) begin
         alive_reg <= load_alive;
      end else begin
         height_reg <= height_next;
         dir_reg    <= dir_next;
         alive_reg  <= alive_next;
         // Every tick consumes the pending flip, even one arriving with it.
         if (tick_en)
            pending_reg <= 1'b0;
         else if (toggle_en)
            pending_reg <= 1'b1;
         if (tick_en && alive_next && score_reg != '1)
            score_reg <= score_reg + 1'b1;
      end
   end

   assign height   = height_reg;
   assign grav_dir = dir_reg;
   assign alive    = alive_reg;
   assign score    = score_reg;

endmodule

// File: rtl/gravity_player_engine.sv
// N-player gravity-flip engine: game FSM, alive popcount, winner latch and per-player slots.
module gravity_player_engine
   import game_pkg::*;
#(
   parameter int NUM_PLAYERS  = 4,
   parameter int HEIGHT_W     = 9,
   parameter int NUM_LANES    = 3,
   parameter int LANE_SPACING = 120,
   parameter int FALL_STEP    = 4,
   parameter int MAX_H        = 479,
   parameter int SCORE_W      = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            tick,
   input  logic                            start,
   input  logic [NUM_PLAYERS-1:0]          enable,
   input  logic [NUM_PLAYERS-1:0]          toggle,
   input  logic [NUM_PLAYERS*NUM_LANES-1:0] lines,
   output logic [NUM_PLAYERS*HEIGHT_W-1:0] height,
   output logic [NUM_PLAYERS-1:0]          grav_dir,
   output logic [NUM_PLAYERS-1:0]          alive,
   output logic [NUM_PLAYERS*SCORE_W-1:0]  score,
   output logic                            running,
   output logic                            game_over,
   output logic [NUM_PLAYERS-1:0]          winner
);

   localparam int CNT_W = $clog2(NUM_PLAYERS + 1);

   game_state_t              state_reg, state_next;
   logic [NUM_PLAYERS-1:0]   winner_reg, winner_next;
   logic                     multi_reg, multi_next;
   logic [NUM_PLAYERS-1:0]   alive_next;
   logic [CNT_W-1:0]         alive_cnt, enable_cnt;
   logic                     in_run, load;

   assign in_run = (state_reg == ST_RUN);
   assign load   = (state_reg == ST_IDLE) && start && (enable != '0);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_slot
         player_slot #(
            .HEIGHT_W     (HEIGHT_W),
            .NUM_LANES    (NUM_LANES),
            .LANE_SPACING (LANE_SPACING),
            .FALL_STEP    (FALL_STEP),
            .MAX_H        (MAX_H),
            .SCORE_W      (SCORE_W)
         ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .tick_en    (in_run && tick),
            .toggle_en  (in_run && toggle[gi]),
            .load       (load),
            .load_alive (enable[gi]),
            .lines      (lines[gi*NUM_LANES +: NUM_LANES]),
            .height     (height[gi*HEIGHT_W +: HEIGHT_W]),
            .grav_dir   (grav_dir[gi]),
            .alive      (alive[gi]),
            .score      (score[gi*SCORE_W +: SCORE_W]),
            .alive_next (alive_next[gi])
         );
      end
   endgenerate

   always_comb begin
      alive_cnt  = '0;
      enable_cnt = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         alive_cnt  = alive_cnt + CNT_W'(alive_next[i]);
         enable_cnt = enable_cnt + CNT_W'(enable[i]);
      end
   end

   always_comb begin
      state_next  = state_reg;
      winner_next = winner_reg;
      multi_next  = multi_reg;
      case (state_reg)
         ST_IDLE: begin
            if (load) begin
               state_next = ST_RUN;
               multi_next = (enable_cnt > CNT_W'(1));
            end
         end
         ST_RUN: begin
            // Judged on post-update alive so OVER lands on the deciding edge.
            if (multi_reg ? (alive_cnt <= CNT_W'(1)) : (alive_cnt == '0)) begin
               state_next  = ST_OVER;
               winner_next = (alive_cnt == CNT_W'(1)) ? alive_next : '0;
            end
         end
         default: state_next = state_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         winner_reg <= '0;
         multi_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         winner_reg <= winner_next;
         multi_reg  <= multi_next;
      end
   end

   assign running   = (state_reg == ST_RUN);
   assign game_over = (state_reg == ST_OVER);
   assign winner    = winner_reg;

endmodule

// File: tb/tb_gravity_player_engine.sv
// Directed-vector bench for gravity_player_engine with hand-computed expectations.
module tb_gravity_player_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  enable = '0;
   logic [3:0]  toggle = '0;
   logic [11:0] lines = '0;
   logic [35:0] height;
   logic [3:0]  grav_dir;
   logic [3:0]  alive;
   logic [63:0] score;
   logic        running;
   logic        game_over;
   logic [3:0]  winner;

   int errors = 0;
   int checks = 0;

   localparam logic [35:0] ALL_START = {4{9'd240}};

   always #5 clk = ~clk;

   gravity_player_engine dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .start     (start),
      .enable    (enable),
      .toggle    (toggle),
      .lines     (lines),
      .height    (height),
      .grav_dir  (grav_dir),
      .alive     (alive),
      .score     (score),
      .running   (running),
      .game_over (game_over),
      .winner    (winner)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         step();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b want=0", running); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got=%b want=0", game_over); end
      checks++; if (alive !== 4'b0000) begin errors++; $display("FAIL reset_alive got=%b want=0000", alive); end
      checks++; if (height !== ALL_START) begin errors++; $display("FAIL reset_height got=%h want=%h", height, ALL_START); end
      checks++; if (score !== 64'd0 || grav_dir !== 4'd0 || winner !== 4'd0) begin errors++; $display("FAIL reset_misc score=%h dir=%b win=%b want=0", score, grav_dir, winner); end
      $display("test_reset done");
   endtask

   task automatic test_start();
      enable = 4'b0101;
      lines  = 12'hFFF;
      start  = 1'b1;
      tick   = 1'b1;            // coincident tick must be ignored
      step();
      start = 1'b0;
      tick  = 1'b0;
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got=%b want=1", running); end
      checks++; if (alive !== 4'b0101) begin errors++; $display("FAIL start_alive got=%b want=0101", alive); end
      checks++; if (height !== ALL_START || grav_dir !== 4'b0000) begin errors++; $display("FAIL start_pos h=%h dir=%b", height, grav_dir); end
      checks++; if (score !== 64'd0) begin errors++; $display("FAIL start_tick_ignored score=%h want=0", score); end
      $display("test_start done");
   endtask

   task automatic test_ground_hold();
      do_ticks(10);
      checks++; if (height[8:0] !== 9'd240) begin errors++; $display("FAIL hold_h0 got=%0d want=240", height[8:0]); end
      checks++; if (score[15:0] !== 16'd10) begin errors++; $display("FAIL hold_score0 got=%0d want=10", score[15:0]); end
      $display("test_ground_hold done");
   endtask

   task automatic test_flip_climb();
      toggle[0] = 1'b1;
      step();
      toggle[0] = 1'b0;
      do_ticks(1);
      checks++; if (grav_dir[0] !== 1'b1) begin errors++; $display("FAIL flip_dir0 got=%b want=1", grav_dir[0]); end
      checks++; if (height[8:0] !== 9'd244) begin errors++; $display("FAIL flip_h0 got=%0d want=244", height[8:0]); end
      do_ticks(29);
      checks++; if (height[8:0] !== 9'd360) begin errors++; $display("FAIL climb_h0 got=%0d want=360", height[8:0]); end
      do_ticks(3);
      checks++; if (height[8:0] !== 9'd360) begin errors++; $display("FAIL land_hold_h0 got=%0d want=360", height[8:0]); end
      checks++; if (score[15:0] !== 16'd43 || score[47:32] !== 16'd43) begin errors++; $display("FAIL climb_scores s0=%0d s2=%0d want=43", score[15:0], score[47:32]); end
      $display("test_flip_climb done");
   endtask

   task automatic test_fall_death();
      lines[8:6] = 3'b000;
      do_ticks(59);
      checks++; if (height[26:18] !== 9'd4 || alive !== 4'b0101) begin errors++; $display("FAIL fall59 h2=%0d alive=%b want=4/0101", height[26:18], alive); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL fall59_running got=%b want=1", running); end
      do_ticks(1);
      checks++; if (height[26:18] !== 9'd0 || alive !== 4'b0001) begin errors++; $display("FAIL death h2=%0d alive=%b want=0/0001", height[26:18], alive); end
      checks++; if (game_over !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL over_flags go=%b run=%b want=1/0", game_over, running); end
      checks++; if (winner !== 4'b0001) begin errors++; $display("FAIL winner got=%b want=0001", winner); end
      do_ticks(1);
      checks++; if (score[15:0] !== 16'd103 || height[8:0] !== 9'd360) begin errors++; $display("FAIL over_frozen s0=%0d h0=%0d want=103/360", score[15:0], height[8:0]); end
      $display("test_fall_death done");
   endtask

   task automatic test_airborne_toggle();
      do_reset();
      enable = 4'b0011;
      lines  = 12'hFFF;
      start  = 1'b1;
      step();
      start = 1'b0;
      lines[2:0] = 3'b000;
      do_ticks(1);
      checks++; if (height[8:0] !== 9'd236) begin errors++; $display("FAIL air_h0 got=%0d want=236", height[8:0]); end
      toggle[0] = 1'b1;
      step();
      toggle[0] = 1'b0;
      do_ticks(1);
      checks++; if (grav_dir[0] !== 1'b0 || height[8:0] !== 9'd232) begin errors++; $display("FAIL air_toggle dir0=%b h0=%0d want=0/232", grav_dir[0], height[8:0]); end
      toggle[1] = 1'b1;
      reset     = 1'b1;
      step();
      toggle[1] = 1'b0;
      reset     = 1'b0;
      checks++; if (running !== 1'b0 || height !== ALL_START || alive !== 4'd0) begin errors++; $display("FAIL toggle_reset run=%b h=%h alive=%b", running, height, alive); end
      lines = 12'hFFF;
      start = 1'b1;
      step();
      start = 1'b0;
      do_ticks(1);
      checks++; if (grav_dir !== 4'b0000 || height[17:9] !== 9'd240) begin errors++; $display("FAIL no_flip dir=%b h1=%0d want=0000/240", grav_dir, height[17:9]); end
      $display("test_airborne_toggle done");
   endtask

   task automatic test_double_death();
      lines[5:0] = 6'b000000;
      do_ticks(59);
      checks++; if (alive !== 4'b0011 || running !== 1'b1) begin errors++; $display("FAIL dbl59 alive=%b run=%b want=0011/1", alive, running); end
      do_ticks(1);
      checks++; if (alive !== 4'b0000 || game_over !== 1'b1) begin errors++; $display("FAIL dbl_death alive=%b go=%b want=0000/1", alive, game_over); end
      checks++; if (winner !== 4'b0000) begin errors++; $display("FAIL dbl_winner got=%b want=0000", winner); end
      do_reset();
      enable = 4'b0000;
      start  = 1'b1;
      step();
      start = 1'b0;
      step();
      checks++; if (running !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL empty_start run=%b go=%b want=0/0", running, game_over); end
      $display("test_double_death done");
   endtask

   initial begin
      step();
      test_reset();
      test_start();
      test_ground_hold();
      test_flip_climb();
      test_fall_death();
      test_airborne_toggle();
      test_double_death();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gravity_player_engine.md
# gravity_player_engine

Parametrised N-player gravity-flip game engine: per-player height, gravity direction, death and survival score, plus the IDLE/RUN/OVER game FSM and winner detection. It sits between the debounced player buttons, the game-tick divider and the line generators, and feeds heights and status to the display. It supersedes the fixed four-player hand-instantiated dead/gravity/move chain and its start latch.

## Interface
- NUM_PLAYERS, 4: player slots.
- HEIGHT_W, 9: height width; 0 = screen bottom.
- NUM_LANES, 3: ground lanes; lane k sits at y = (k+1)*LANE_SPACING, k=0 lowest.
- LANE_SPACING, 120: lane pitch. Requires NUM_LANES*LANE_SPACING < MAX_H.
- FALL_STEP, 4: pixels moved per tick when airborne.
- MAX_H, 479: ceiling height.
- SCORE_W, 16: survival-counter width.

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high.
- tick in 1: one-cycle game-tick strobe.
- start in 1: game start request.
- enable in NUM_PLAYERS: player-enable switches.
- toggle in NUM_PLAYERS: debounced gravity-flip pulses.
- lines in NUM_PLAYERS*NUM_LANES: lane presence at each player's column; bit [p*NUM_LANES+k].
- height out NUM_PLAYERS*HEIGHT_W: player heights.
- grav_dir out NUM_PLAYERS: 0 = down (decreasing height), 1 = up.
- alive out NUM_PLAYERS: player in play.
- score out NUM_PLAYERS*SCORE_W: ticks survived.
- running out 1: FSM is in RUN.
- game_over out 1: FSM is in OVER.
- winner out NUM_PLAYERS: one-hot last survivor; 0 if none.

## Operation
- START_H = lane y of lane NUM_LANES/2 (240 with defaults).
- Reset values:
  - height = START_H for all players.
  - grav_dir = 0, alive = 0, score = 0.
  - running = 0, game_over = 0, winner = 0.
  - FSM = IDLE, pending toggles = 0.
- FSM:
  - IDLE: tick and toggle are ignored. start with enable != 0 latches alive = enable and goes to RUN. start with enable == 0 is ignored.
  - RUN: players update on each tick. Exit to OVER when the alive count drops to ≤1 (multi-player start) or to 0 (single-player start).
  - OVER: all state frozen; only reset leaves it.
- Toggle: in RUN, a toggle pulse in any cycle sets pending[p]. Every tick clears all pending bits.
- Per-player tick update (alive players only; dead players freeze height, dir and score). Evaluated on pre-tick values:
  - grounded = some present lane k has y == height.
  - grounded and pending: flip dir, then move FALL_STEP in the new direction.
  - grounded, no pending: hold position.
  - not grounded: move FALL_STEP in the current dir. Pending is discarded, so airborne flips are ignored.
- Landing: a move that crosses or reaches a present lane clamps to that lane.
  - Down move: land on the highest present y with h-FALL_STEP ≤ y < h.
  - Up move: land on the lowest present y with h < y ≤ h+FALL_STEP.
  - The departure lane never captures its own flip move.
- Death:
  - Down move that would reach ≤0: height = 0, alive cleared.
  - Up move that would reach ≥MAX_H: height = MAX_H, alive cleared.
  - Compute with one guard bit; no wrap-around.
- Score: increments on each tick where the player is alive after the update. Saturates at all-ones.
- Winner: latched on the RUN→OVER transition = alive vector if exactly one bit is set, else 0.

## Timing
- All outputs are registered. A tick sampled high at edge n is reflected at edge n+1.
- The RUN→OVER transition happens on the same edge as the deciding death.
- Start → running = 1 one cycle later. Start coincident with tick: the tick is ignored.
- A toggle in the same cycle as a tick counts for that tick.
- Reset wins over every other input in the same cycle. Reset mid-RUN returns everything to reset values next edge.
- Simultaneous deaths on one tick: all are recorded. The winner rule then yields 0.

## Structure
- game_pkg holds:
  - FSM state encodings (IDLE/RUN/OVER).
  - the lane_y(k) function.
  - the START_H derivation.
- Sub-module player_slot: one player's height/dir/pending/alive/score datapath. Generate-instantiated NUM_PLAYERS times.
- Top level holds the FSM, alive-count popcount and winner latch.

## Test plan
1. Reset, enable=4'b0101, start → next cycle running=1, alive=0101, all heights 240, grav_dir=0000.
2. p0 lines=3'b111, 10 ticks, no toggles → height0 stays 240, score0=10.
3. p0 toggle then tick with lines=111 → dir0=1, h0=244. 29 more ticks → h0=360 and grounded; further ticks hold 360.
4. p2 lines=000, dir down, from 240 → 4 per tick, alive[2]=0 and h2=0 on tick 60. Game now has only p0 alive → game_over=1, winner=0001.
5. Toggle while airborne, then tick → dir unchanged, pending cleared. Toggle + reset in the same cycle → reset values, no flip.
6. Two remaining players die on the same tick → game_over=1, winner=0000. Start with enable=0000 in IDLE → running stays 0.
